core_seq_ctrl: RTL and testbench

Top-level sequencer for the systolic core. It owns the SRAM port-select (`dut_cl_sel`) and loads the activation SRAM (36x32) and weight SRAM (72x32) from one host word stream. It then pulses `seq_begin`, waits for `seq_done`, and streams the output SRAM (340x128) back to the host with backpressure. It sits between the host/testbench and the core's `dut_*` SRAM ports.

---
 rtl/core_pkg.sv | 28 ++
 rtl/seq_skid_buf.sv | 49 ++++
 rtl/core_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding, widths and SRAM enable levels for the core sequencer
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_ACT,
        LD_W,
        KICK,
        COMPUTE,
        RD,
        DRAIN,
        FIN
    } seq_state_t;

    localparam int ACT_AW = 7;
    localparam int OP_AW  = 9;
    localparam int LD_DW  = 32;
    localparam int OP_DW  = 128;
    localparam int CNT_W  = 9;
    localparam int TMO_W  = 13;

    // SRAM strobes are active-low
    localparam logic CEN_ON  = 1'b0;
    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_WR  = 1'b0;
    localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/seq_skid_buf.sv
// rtl/seq_skid_buf.sv - 2-entry data+last buffer feeding the host readback stream
module seq_skid_buf
    import core_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_tvalid,
    input  logic [OP_DW-1:0] in_tdata,
    input  logic             in_tlast,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [OP_DW-1:0] out_tdata,
    output logic             out_tlast,
    output logic [1:0]       free
);

    logic [OP_DW:0] ent [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;
    logic           pop;

    assign pop        = out_tvalid && out_tready;
    assign out_tvalid = (count != 2'd0);
    assign {out_tlast, out_tdata} = ent[rd_ptr];
    // Slots available next cycle; credits a pop happening this cycle so a
    // steady 1 word/cycle stream never has to pause.
    assign free = 2'd2 - count + {1'b0, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_tvalid) begin
                ent[wr_ptr] <= {in_tlast, in_tdata};
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + {1'b0, in_tvalid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - loads ACT/W SRAMs, kicks the corelet, streams OP SRAM back
// Optional compute watchdog: SEQ_TIMEOUT_EN
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int ACT_DEPTH = 36,
    parameter int W_DEPTH   = 72,
    parameter int OP_DEPTH  = 340,
    parameter int OP_BASE   = 0
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int TMO_CYC   = 4096
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [LD_DW-1:0]  ld_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [OP_DW-1:0]  rd_data,
    output logic              rd_last,
    output logic              cl_sel,
    output logic              seq_begin,
    input  logic              seq_done,
    output logic [LD_DW-1:0]  act_d,
    output logic [ACT_AW-1:0] act_addr,
    output logic              act_cen,
    output logic              act_wen,
    output logic [LD_DW-1:0]  w_d,
    output logic [ACT_AW-1:0] w_addr,
    output logic              w_cen,
    output logic              w_wen,
    output logic [OP_AW-1:0]  op_addr,
    output logic              op_cen,
    output logic              op_wen,
    input  logic [OP_DW-1:0]  op_q
);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_nxt;
    logic             pend;
    logic             pend_last;
    logic             issue;
    logic             last_issue;
    logic [1:0]       free;

`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo, tmo_nxt;
`endif

    assign op_wen     = WEN_RD;
    assign last_issue = (cnt == CNT_W'(OP_DEPTH - 1));
    // A read is issued only if its data will find a slot when it lands.
    assign issue      = (state == RD) && (free > {1'b0, pend});

    seq_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .in_tvalid  (pend),
        .in_tdata   (op_q),
        .in_tlast   (pend_last),
        .out_tvalid (rd_valid),
        .out_tready (rd_ready),
        .out_tdata  (rd_data),
        .out_tlast  (rd_last),
        .free       (free)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            err       <= err_nxt;
            pend      <= issue;
            pend_last <= issue && last_issue;
`ifdef SEQ_TIMEOUT_EN
            tmo       <= tmo_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
`ifdef SEQ_TIMEOUT_EN
        tmo_nxt   = tmo;
`endif
        busy      = 1'b1;
        done      = 1'b0;
        ld_ready  = 1'b0;
        cl_sel    = 1'b1;
        seq_begin = 1'b0;
        act_d     = '0;
        act_addr  = '0;
        act_cen   = CEN_OFF;
        act_wen   = WEN_RD;
        w_d       = '0;
        w_addr    = '0;
        w_cen     = CEN_OFF;
        w_wen     = WEN_RD;
        op_addr   = '0;
        op_cen    = CEN_OFF;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LD_ACT;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            LD_ACT: begin
                ld_ready = 1'b1;
                act_addr = cnt[ACT_AW-1:0];
                if (ld_valid) begin
                    act_cen = CEN_ON;
                    act_wen = WEN_WR;
                    act_d   = ld_data;
                    if (cnt == CNT_W'(ACT_DEPTH - 1)) begin
                        state_nxt = LD_W;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            LD_W: begin
                ld_ready = 1'b1;
                w_addr   = cnt[ACT_AW-1:0];
                if (ld_valid) begin
                    w_cen = CEN_ON;
                    w_wen = WEN_WR;
                    w_d   = ld_data;
                    if (cnt == CNT_W'(W_DEPTH - 1)) begin
                        state_nxt = KICK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            KICK: begin
                cl_sel    = 1'b0;
                seq_begin = 1'b1;
                state_nxt = COMPUTE;
`ifdef SEQ_TIMEOUT_EN
                tmo_nxt   = TMO_W'(1);
`endif
            end
            COMPUTE: begin
                cl_sel = 1'b0;
                if (seq_done) begin
                    state_nxt = RD;
`ifdef SEQ_TIMEOUT_EN
                end else if (tmo == TMO_W'(TMO_CYC - 1)) begin
                    // tmo counts cycles since KICK, so done lands TMO_CYC after it
                    err_nxt   = 1'b1;
                    state_nxt = FIN;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
`endif
                end
            end
            RD: begin
                op_addr = OP_AW'(OP_BASE) + cnt;
                if (issue) begin
                    op_cen = CEN_ON;
                    if (last_issue) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!pend && !rd_valid) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - directed self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;

    localparam int ACT_N = 36;
    localparam int W_N   = 72;
    localparam int OP_N  = 340;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy, done, err;
    logic         ld_valid, ld_ready;
    logic [31:0]  ld_data;
    logic         rd_valid, rd_ready, rd_last;
    logic [127:0] rd_data;
    logic         cl_sel, seq_begin, seq_done;
    logic [31:0]  act_d, w_d;
    logic [6:0]   act_addr, w_addr;
    logic         act_cen, act_wen, w_cen, w_wen;
    logic [8:0]   op_addr;
    logic         op_cen, op_wen;
    logic [127:0] op_q = '0;

    core_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .cl_sel(cl_sel), .seq_begin(seq_begin), .seq_done(seq_done),
        .act_d(act_d), .act_addr(act_addr), .act_cen(act_cen), .act_wen(act_wen),
        .w_d(w_d), .w_addr(w_addr), .w_cen(w_cen), .w_wen(w_wen),
        .op_addr(op_addr), .op_cen(op_cen), .op_wen(op_wen), .op_q(op_q)
    );

    always #5 clk = ~clk;

    logic [31:0]  act_mem [0:127];
    logic [31:0]  w_mem   [0:127];
    logic [127:0] op_mem  [0:511];

    always @(posedge clk) begin
        if (!act_cen && !act_wen) act_mem[act_addr] <= act_d;
        if (!w_cen && !w_wen) w_mem[w_addr] <= w_d;
        if (!op_cen) op_q <= op_mem[op_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Model state: beat index, readout index, read-issue index, ownership phase
    int           mk, rk, ri, wr_act, wr_w, begin_cnt, done_cnt;
    int           cyc = 0, first_rd_cyc, first_v_cyc;
    logic         in_core, stalled, mon_en = 1'b0;
    logic [127:0] prev_data, first_word, last_word;

    always @(negedge clk) begin
        cyc++;
        if (reset && mon_en) begin
            if (ld_valid && ld_ready) begin
                if (mk < ACT_N)
                    chk("ld_act_write", 128'({act_cen, act_wen, w_cen, act_addr, act_d}),
                        128'({3'b001, 7'(mk), 32'h1000 + 32'(mk)}));
                else
                    chk("ld_w_write", 128'({w_cen, w_wen, act_cen, w_addr, w_d}),
                        128'({3'b001, 7'(mk - ACT_N), 32'h2000 + 32'(mk - ACT_N)}));
                mk++;
            end else begin
                chk("ld_no_write", 128'({act_cen, w_cen}), 128'(2'b11));
            end
            if (!act_cen && !act_wen) wr_act++;
            if (!w_cen && !w_wen) wr_w++;

            if (stalled) begin
                chk("rd_hold_valid", 128'(rd_valid), 128'(1));
                chk("rd_hold_data", rd_data, prev_data);
            end
            if (rd_valid) begin
                if (first_v_cyc < 0) first_v_cyc = cyc;
                chk("rd_last", 128'(rd_last), 128'(rk == OP_N - 1));
            end
            if (rd_valid && rd_ready) begin
                if (rk < OP_N) chk("rd_data", rd_data, op_mem[rk]);
                else chk("rd_overrun", 128'(rk), 128'(OP_N - 1));
                if (rk == 0) first_word = rd_data;
                last_word = rd_data;
                rk++;
            end
            stalled   = rd_valid && !rd_ready;
            prev_data = rd_data;

            if (!op_cen) begin
                if (ri == 0) first_rd_cyc = cyc;
                chk("op_addr", 128'(op_addr), 128'(ri));
                ri++;
            end

            if (seq_begin) begin
                begin_cnt++;
                in_core = 1'b1;
            end
            chk("cl_sel", 128'(cl_sel), 128'(!in_core));
            if (in_core && seq_done && !seq_begin) in_core = 1'b0;

            if (done) begin
                done_cnt++;
                chk("busy_at_done", 128'(busy), 128'(0));
            end
        end
    end

    // Corelet stub: seq_done `done_delay` cycles after seq_begin, optionally also in the KICK cycle
    int   done_delay = 50;
    logic early_done = 1'b0;
    initial begin
        seq_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            seq_done = 1'b0;
            if (reset && seq_begin) begin
                seq_done = early_done;
                for (int k = 0; k < done_delay - 1 && reset; k++) begin
                    @(posedge clk); #1;
                    seq_done = 1'b0;
                end
                if (reset) begin
                    @(posedge clk); #1;
                    seq_done = 1'b1;
                end
            end
        end
    end

    // Host sink: rd_ready always 1, or the repeating pattern 1,0,0,1
    logic rd_mode = 1'b0;
    initial begin
        int rc = 0;
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rd_ready = rd_mode ? ((rc % 4 == 0) || (rc % 4 == 3)) : 1'b1;
            rc++;
        end
    end

    task automatic load_words(input bit gap);
        int i = 0;
        int c = 0;
        while (i < ACT_N + W_N && c < 2000) begin
            ld_valid = !(gap && (c % 3 == 2));
            ld_data  = (i < ACT_N) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i - ACT_N);
            start    = gap && (c == 10);
            @(negedge clk);
            if (ld_valid && ld_ready) i++;
            @(posedge clk); #1;
            c++;
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        chk("load_beats", 128'(i), 128'(ACT_N + W_N));
    endtask

    task automatic begin_run(input bit rmode, input bit early, input int delay);
        for (int i = 0; i < 128; i++) begin
            act_mem[i] = 32'hdead_beef;
            w_mem[i]   = 32'hdead_beef;
        end
        mk = 0; rk = 0; ri = 0; wr_act = 0; wr_w = 0; begin_cnt = 0; done_cnt = 0;
        in_core = 1'b0; stalled = 1'b0; first_rd_cyc = -1; first_v_cyc = -1;
        rd_mode = rmode; early_done = early; done_delay = delay; mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_seq(input bit gap, input bit rmode, input bit early, input int delay);
        int n = 0;
        begin_run(rmode, early, delay);
        chk("busy_during_run", 128'(busy), 128'(1));
        load_words(gap);
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("done_pulses", 128'(done_cnt), 128'(1));
        chk("busy_after", 128'(busy), 128'(0));
        chk("begin_pulses", 128'(begin_cnt), 128'(1));
        chk("act_writes", 128'(wr_act), 128'(ACT_N));
        chk("w_writes", 128'(wr_w), 128'(W_N));
        chk("rd_count", 128'(rk), 128'(OP_N));
        chk("op_reads", 128'(ri), 128'(OP_N));
        chk("rd_latency", 128'(first_v_cyc - first_rd_cyc), 128'(2));
        chk("first_word", first_word, 128'd0);
        chk("last_word", last_word, 128'd339);
        chk("act_mem_35", 128'(act_mem[35]), 128'h1023);
        chk("w_mem_71", 128'(w_mem[71]), 128'h2047);
        chk("idle_ctrl", 128'({err, cl_sel, op_wen, rd_valid}), 128'(4'b0110));
        for (int i = 0; i < ACT_N; i++)
            chk("act_mem", 128'(act_mem[i]), 128'(32'h1000 + 32'(i)));
        for (int i = 0; i < W_N; i++)
            chk("w_mem", 128'(w_mem[i]), 128'(32'h2000 + 32'(i)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        for (int i = 0; i < 512; i++) op_mem[i] = 128'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 128'({busy, done, err, ld_ready, rd_valid, rd_last, seq_begin, cl_sel}),
            128'(8'b0000_0001));
        chk("rst_strobes", 128'({act_cen, act_wen, w_cen, w_wen, op_cen, op_wen}), 128'(6'b111111));
        chk("rst_addr", 128'({act_addr, w_addr, op_addr}), 128'(0));
        chk("rst_wdata", 128'({act_d, w_d}), 128'(0));
        chk("rst_rd_data", rd_data, 128'(0));
        @(posedge clk); #1 reset = 1'b1;

        run_seq(1'b0, 1'b0, 1'b0, 50);
        run_seq(1'b1, 1'b1, 1'b1, 50);

        // Abort a run during COMPUTE with reset, then run again from scratch
        begin_run(1'b0, 1'b0, 1000);
        load_words(1'b0);
        n = 0;
        while (begin_cnt == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_kicked", 128'(begin_cnt), 128'(1));
        repeat (10) @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("mid_rst_ctrl", 128'({cl_sel, busy, seq_begin, ld_ready, done, rd_valid}),
            128'(6'b100000));
        chk("mid_rst_strobes", 128'({act_cen, w_cen, op_cen}), 128'(3'b111));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        run_seq(1'b0, 1'b1, 1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
